uart_rx: RTL and testbench

UART receiver: 8N1 serial input, one start bit, 8 data bits LSB first, one stop bit. Same frame format and baud parameters as the UART transmitter, so a transmitter's `tx` line can drive this block's `rx` directly in a loopback. Sits on the CPU-facing UART peripheral. Delivers received bytes through a valid/read handshake, with framing-error and overrun status.

---
 rtl/uart_rx.sv | 127 ++++++++++++
 tb/tb_uart_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of a synchronized serial line, with a
// valid/read handshake and framing-error / overrun status for the consumer.
module uart_rx #(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned CLK_COUNT_BIT = CLK_FREQ / BAUD_RATE,
  parameter int unsigned HALF_BIT      = CLK_COUNT_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic       rx,
  input  logic       read,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [31:0] BIT_LAST  = 32'(CLK_COUNT_BIT - 1);
  localparam logic [31:0] HALF_LAST = 32'(HALF_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic        rx_meta;
  logic        rx_s;
  logic [31:0] clk_count;
  logic [2:0]  bit_count;
  logic [7:0]  shift;
  logic        complete;

  // Two-flop synchronizer; idle-high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign complete = (state == STOP) && (clk_count == BIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      clk_count <= 32'd0;
      bit_count <= 3'd0;
      shift     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // A read in the completion cycle is folded into the load below.
      if (read && valid && !complete) begin
        valid     <= 1'b0;
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end

      case (state)
        IDLE: begin
          clk_count <= 32'd0;
          bit_count <= 3'd0;
          if (rx_en && !rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (clk_count == HALF_LAST) begin
            clk_count <= 32'd0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_count <= clk_count + 32'd1;
          end
        end

        DATA: begin
          if (clk_count == BIT_LAST) begin
            shift[bit_count] <= rx_s;
            bit_count        <= bit_count + 3'd1;
            clk_count        <= 32'd0;
            if (bit_count == 3'd7) state <= STOP;
          end else begin
            clk_count <= clk_count + 32'd1;
          end
        end

        STOP: begin
          if (clk_count == BIT_LAST) begin
            clk_count <= 32'd0;
            state     <= IDLE;
            busy      <= 1'b0;
            if (!valid || read) begin
              data      <= shift;
              valid     <= 1'b1;
              frame_err <= ~rx_s;
              overrun   <= 1'b0;
            end else begin
              overrun   <= 1'b1;
            end
          end else begin
            clk_count <= clk_count + 32'd1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit, driven by a
// per-cycle transmitter model and checked against a consumer-side model.
module tb_uart_rx;

  localparam int unsigned CB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_en;
  logic       rx;
  logic       read;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ferr;
  logic       m_ovr;

  uart_rx #(
    .CLK_FREQ (1_600_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_en    (rx_en),
    .rx       (rx),
    .read     (read),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_data"},  data,            m_data);
    chk({tag, "_valid"}, 8'(valid),       8'(m_valid));
    chk({tag, "_ferr"},  8'(frame_err),   8'(m_ferr));
    chk({tag, "_ovr"},   8'(overrun),     8'(m_ovr));
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Line rx is driven once per cycle at the falling edge; cycle c is followed
  // by rising edge P_c. The synchronizer makes edge P2 the start detection,
  // so the stop bit is sampled on P154 (2 + 8 + 9*16).
  task automatic send(input logic [7:0] d, input logic stop, input logic rd_at_stop,
                      input logic expect_rx, input int abort_at, input int gap);
    logic [9:0] frame;
    frame = {stop, d, 1'b0};
    for (int c = 0; c < 160; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        reset = 1'b1;
        #1;
        model_reset();
        check_state("rst_mid");
        chk("rst_mid_busy", 8'(busy), 8'd0);
        @(negedge clk);
        reset = 1'b0;
        rx    = 1'b1;
        read  = 1'b0;
        return;
      end
      if (expect_rx) begin
        if (c == 2) chk("busy_pre", 8'(busy), 8'd0);
        if (c == 3) chk("busy_start", 8'(busy), 8'd1);
        if (c == 154) begin
          chk("busy_stop", 8'(busy), 8'd1);
          chk("valid_pre", 8'(valid), 8'(m_valid));
        end
        if (c == 155) begin
          if (!m_valid || rd_at_stop) begin
            m_data  = d;
            m_valid = 1'b1;
            m_ferr  = ~stop;
            m_ovr   = 1'b0;
          end else begin
            m_ovr = 1'b1;
          end
          chk("busy_done", 8'(busy), 8'd0);
          check_state("frame");
        end
      end else begin
        if (c == 3) chk("busy_dis", 8'(busy), 8'd0);
        if (c == 155) check_state("disabled");
      end
      rx   = frame[4'(c / CB)];
      read = rd_at_stop && (c == 154);
    end
    repeat (gap) begin
      @(negedge clk);
      rx   = 1'b1;
      read = 1'b0;
    end
    rx = 1'b1;
  endtask

  task automatic do_read();
    @(negedge clk);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
    end
    check_state("read");
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    int         mode;

    reset = 1'b1;
    rx_en = 1'b0;
    rx    = 1'b1;
    read  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("reset");
    chk("reset_busy", 8'(busy), 8'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Basic receive
    rx_en = 1'b1;
    send(8'hA5, 1'b1, 1'b0, 1'b1, -1, 20);
    do_read();

    // Framing error
    send(8'h3C, 1'b0, 1'b0, 1'b1, -1, 20);
    do_read();

    // Glitch: start sample at P10 sees the line high again
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 10) chk("glitch_busy", 8'(busy), 8'd1);
      if (c == 11) chk("glitch_idle", 8'(busy), 8'd0);
      rx = (c < 4) ? 1'b0 : 1'b1;
    end
    check_state("glitch");

    // Receiver disabled
    rx_en = 1'b0;
    send(8'h55, 1'b1, 1'b0, 1'b0, -1, 20);
    rx_en = 1'b1;

    // Overrun, then simultaneous read and completion
    send(8'h11, 1'b1, 1'b0, 1'b1, -1, 20);
    send(8'h22, 1'b1, 1'b0, 1'b1, -1, 20);
    send(8'h33, 1'b1, 1'b1, 1'b1, -1, 20);
    send(8'h44, 1'b1, 1'b0, 1'b1, -1, 20);

    // Reset during data bit 3, then a clean frame
    send(8'h5A, 1'b1, 1'b0, 1'b1, 70, 0);
    repeat (20) @(negedge clk);
    send(8'h81, 1'b1, 1'b0, 1'b1, -1, 20);
    do_read();

    // Back-to-back frames; second completion also reads the first byte
    send(8'h00, 1'b1, 1'b0, 1'b1, -1, 0);
    send(8'hFF, 1'b1, 1'b1, 1'b1, -1, 20);
    do_read();

    // Randomized frames with random stop bit and consumer behaviour
    for (int n = 0; n < 12; n++) begin
      rb   = 8'($urandom_range(0, 255));
      rs   = ($urandom_range(0, 4) != 0);
      mode = int'($urandom_range(0, 2));
      send(rb, rs, (mode == 1), 1'b1, -1, 20);
      if (mode == 2) do_read();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
